svpwm_sine_duty_gen: RTL
========================

# svpwm_sine_duty_gen

Upstream duty-cycle source for the three-phase PWM stage. Once per PWM period it advances a 32-bit phase accumulator and computes three 120°-spaced sinusoidal duty values scaled to the active `Period`. It then presents them as a coherent set on `Duty_0/1/2`. The PWM stage's period-boundary interrupt drives `Update_Strobe`, and the PWM stage latches the new duties at its next counter wrap.

## Interface

Parameters:
- `LUT_ADDR_W`, default 8: sine table depth is 2^LUT_ADDR_W, one full cycle.
- `LUT_DATA_W`, default 16: signed Q1.15 table entries.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Enable`  in  1  0 aborts any computation and parks the outputs at 50 %.
- `Update_Strobe`  in  1  one-cycle pulse, once per PWM period.
- `Period`  in  32  PWM period in counts; the same value the PWM stage uses.
- `Amplitude`  in  16  modulation index, unsigned Q0.16 (0xFFFF ≈ 1.0).
- `Phase_Step`  in  32  phase increment added per update; 2^32 = 360°.
- `Duty_0`, `Duty_1`, `Duty_2`  out  32  duty counts, range 0..Period.
- `Duty_Valid`  out  1  one-cycle pulse when a new set is committed.
- `Busy`  out  1  high while a computation is in progress.
- `Overrun`  out  1  sticky; set when a strobe arrives while Busy.
- `Theta`  out  32  current phase accumulator value.

## Operation

- Reset values: `Theta`=0, `Duty_*`=0, `Duty_Valid`=0, `Busy`=0, `Overrun`=0, FSM=IDLE.
- FSM states: IDLE → ACC → (READ → SCALE → MAP) for k=0,1,2 → COMMIT → IDLE.
- **IDLE**
  - If `Update_Strobe` and `Enable`, go to ACC.
  - Otherwise hold.
- **ACC**
  - `Theta <= Theta + Phase_Step`, wrapping modulo 2^32.
  - Snapshot `Period` and `Amplitude` into internal registers; later input changes do not affect the set in progress.
- **READ**
  - θk = Theta + OFFk, with OFF = {0x00000000, 0x55555555, 0xAAAAAAAA}.
  - Sine ROM address = θk[31:32-LUT_ADDR_W].
  - ROM is synchronous with 1-cycle latency.
- **SCALE**
  - m = (s × Amplitude) >>> 16, where s is the signed table entry.
  - Result is signed 16-bit; arithmetic shift, floor.
- **MAP**
  - h = Period >> 1.
  - dk = h + ((m × h) >>> 15), using a 48-bit signed product.
  - Clamp dk to [0, Period]; store in a staging register.
- **COMMIT**
  - All three `Duty_*` update together from staging.
  - `Duty_Valid` = 1 for this cycle only.
- `Busy` = 1 in every state except IDLE.
- `Update_Strobe` while Busy: the strobe is ignored, `Overrun` <= 1, and the current computation continues.
- `Enable` low in any state:
  - Next edge: FSM goes to IDLE and all `Duty_*` become Period>>1.
  - No `Duty_Valid` pulse.
  - `Theta` is held.
  - `Overrun` is cleared.
- `Reset` mid-computation: all registers take their reset values at that edge, and the staged set is discarded.
- Sine ROM contents: entry i = round(32767·sin(2πi/2^LUT_ADDR_W)).

## Timing

- Edge E0 samples `Update_Strobe`.
- ACC occupies E1; the three phases occupy E2..E10 (3 cycles each); COMMIT is at E11.
- `Duty_*` and `Duty_Valid` are visible after E11, a fixed latency of 11 cycles.
- `Busy` is high from after E0 through the COMMIT cycle.
- Required operating condition: Period ≥ 16, so a set always commits before the PWM stage's next wrap.
- A strobe coinciding with the COMMIT cycle counts as Busy and triggers Overrun.
- `Duty_*` outputs are glitch-free and change only at COMMIT, Enable-low or Reset.

## Structure

- Package `svpwm_pkg` holds:
  - the FSM state enum;
  - phase offset constants OFF0/1/2;
  - LUT width constants;
  - the 50 % park rule, as a function or constant.
- Sub-module `sine_lut_rom`: 2^LUT_ADDR_W × LUT_DATA_W synchronous ROM, initialised from a generated memory file.
- One multiplier path is shared across the three phases; the SCALE and MAP products are computed in separate cycles.

## Test plan

- Reset, then Period=1000, Amplitude=0: strobe → after 11 cycles `Duty_0/1/2` = 500/500/500, `Duty_Valid` pulses once, `Theta`=Phase_Step.
- Period=1000, Amplitude=0xFFFF, Phase_Step=0x40000000, first strobe → `Theta`=0x40000000 and `Duty_0`=999; `Duty_1` and `Duty_2` match the bit-exact reference model.
- Phase_Step=0x01000000 over 300 strobes → `Theta` wraps past 2^32 and duties stay within [0, 1000]; all three sequences match the model and are 120° apart.
- Second strobe 5 cycles after the first → `Overrun`=1, exactly one `Duty_Valid` pulse, and the result equals the single-strobe result.
- Drop `Enable` during SCALE of phase 1 → next cycle `Busy`=0 and `Duty_*` = Period>>1 = 500; no `Duty_Valid` pulse; `Theta` unchanged.
- Assert `Reset` during MAP of phase 2 → next cycle all outputs are 0, `Busy`=0, `Theta`=0; a subsequent strobe behaves exactly as in the first scenario.

Source files
------------

// File: rtl/svpwm_pkg.sv
// Shared types and constants for the SVPWM sine duty generator.
package svpwm_pkg;

  localparam int SINE_ADDR_W = 8;
  localparam int SINE_DATA_W = 16;

  // Phase offsets of the three outputs: 0, 120 and 240 degrees.
  localparam logic [31:0] OFF0 = 32'h0000_0000;
  localparam logic [31:0] OFF1 = 32'h5555_5555;
  localparam logic [31:0] OFF2 = 32'hAAAA_AAAA;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_READ   = 3'd2,
    ST_SCALE  = 3'd3,
    ST_MAP    = 3'd4,
    ST_COMMIT = 3'd5
  } svpwm_state_e;

  // Quarter wave of round(32767*sin(2*pi*i/256)), i = 0..64. The ROM
  // unfolds the remaining three quadrants by symmetry.
  localparam logic [15:0] QSINE [0:64] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
    16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
    16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
    16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
    16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
    16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
    16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
    16'd32767
  };

  // Parked (50 %) duty for a given PWM period.
  function automatic logic [31:0] park_duty(input logic [31:0] period);
    return period >> 1;
  endfunction

endpackage

// File: rtl/sine_lut_rom.sv
// Full-cycle signed sine ROM with one-cycle synchronous read, built from the
// quarter-wave table in svpwm_pkg (table generated for a 256-entry cycle).
module sine_lut_rom
  import svpwm_pkg::*;
#(
  parameter int ADDR_W = SINE_ADDR_W,
  parameter int DATA_W = SINE_DATA_W
) (
  input  logic                     Clk,
  input  logic [ADDR_W-1:0]        addr,
  output logic signed [DATA_W-1:0] data
);

  localparam logic [ADDR_W-2:0] QTR_IDX = (ADDR_W-1)'(1 << (ADDR_W-2));

  logic [1:0]               quad;
  logic [ADDR_W-3:0]        frac;
  logic [ADDR_W-2:0]        q_idx;
  logic signed [DATA_W-1:0] mag;
  logic signed [DATA_W-1:0] val;

  // Fold the address onto the quarter wave, mirror in odd quadrants, negate in the lower half.
  always_comb begin
    quad  = addr[ADDR_W-1 -: 2];
    frac  = addr[ADDR_W-3:0];
    q_idx = quad[0] ? (QTR_IDX - {1'b0, frac}) : {1'b0, frac};
    mag   = DATA_W'(QSINE[q_idx]);
    val   = quad[1] ? -mag : mag;
  end

  // Registered read port.
  always_ff @(posedge Clk) begin
    data <= val;
  end

endmodule

// File: rtl/svpwm_sine_duty_gen.sv
// Three-phase sinusoidal duty generator: one coherent duty set per update strobe.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for Update_Strobe
// ST_ACC    | advance Theta, snapshot Period/Amplitude, k = 0
// ST_READ   | sine ROM address for phase k presented
// ST_SCALE  | m = (s * Amplitude) >>> 16
// ST_MAP    | stage[k] = clamp(h + ((m * h) >>> 15)); k++
// ST_COMMIT | copy staging set to Duty_*, pulse Duty_Valid
module svpwm_sine_duty_gen
  import svpwm_pkg::*;
#(
  parameter int LUT_ADDR_W = SINE_ADDR_W,
  parameter int LUT_DATA_W = SINE_DATA_W
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        Update_Strobe,
  input  logic [31:0] Period,
  input  logic [15:0] Amplitude,
  input  logic [31:0] Phase_Step,
  output logic [31:0] Duty_0,
  output logic [31:0] Duty_1,
  output logic [31:0] Duty_2,
  output logic        Duty_Valid,
  output logic        Busy,
  output logic        Overrun,
  output logic [31:0] Theta
);

  svpwm_state_e state, state_nxt;

  logic [1:0]                   k;
  logic [31:0]                  period_q;
  logic [15:0]                  amp_q;
  logic signed [15:0]           m_q;
  logic [31:0]                  stage_0, stage_1, stage_2;

  logic [31:0]                  off_k;
  logic [LUT_ADDR_W-1:0]        rom_addr;
  logic signed [LUT_DATA_W-1:0] rom_data;

  logic [31:0]                  half;
  logic signed [15:0]           mul_a;
  logic signed [32:0]           mul_b;
  logic signed [48:0]           mul_p;
  logic signed [48:0]           prod_shift;
  logic signed [49:0]           half_s;
  logic signed [49:0]           period_s;
  logic signed [49:0]           map_sum;
  logic [31:0]                  map_val;

  sine_lut_rom #(
    .ADDR_W (LUT_ADDR_W),
    .DATA_W (LUT_DATA_W)
  ) u_rom (
    .Clk  (Clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Phase-k ROM address; the full 32-bit add keeps the carry from the low bits.
  always_comb begin
    case (k)
      2'd0:    off_k = OFF0;
      2'd1:    off_k = OFF1;
      default: off_k = OFF2;
    endcase
    rom_addr = LUT_ADDR_W'((Theta + off_k) >> (32 - LUT_ADDR_W));
  end

  // Single shared multiplier: sine x amplitude in SCALE, m x h in MAP; then clamp.
  always_comb begin
    half = period_q >> 1;
    if (state == ST_MAP) begin
      mul_a = m_q;
      mul_b = $signed({1'b0, half});
    end else begin
      mul_a = rom_data;
      mul_b = $signed({17'b0, amp_q});
    end
    mul_p      = 49'(mul_a) * 49'(mul_b);
    prod_shift = mul_p >>> 15;
    half_s     = $signed({18'b0, half});
    period_s   = $signed({18'b0, period_q});
    map_sum    = half_s + 50'(prod_shift);
    if (map_sum < 0)
      map_val = '0;
    else if (map_sum > period_s)
      map_val = period_q;
    else
      map_val = map_sum[31:0];
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and Busy; Enable low forces IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    Busy      = (state != ST_IDLE);
    if (!Enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (Update_Strobe) state_nxt = ST_ACC;
        ST_ACC:    state_nxt = ST_READ;
        ST_READ:   state_nxt = ST_SCALE;
        ST_SCALE:  state_nxt = ST_MAP;
        ST_MAP:    state_nxt = (k == 2'd2) ? ST_COMMIT : ST_READ;
        ST_COMMIT: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath registers, staging set and outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Theta      <= '0;
      Duty_0     <= '0;
      Duty_1     <= '0;
      Duty_2     <= '0;
      Duty_Valid <= 1'b0;
      Overrun    <= 1'b0;
      k          <= '0;
      period_q   <= '0;
      amp_q      <= '0;
      m_q        <= '0;
      stage_0    <= '0;
      stage_1    <= '0;
      stage_2    <= '0;
    end else if (!Enable) begin
      Duty_0     <= park_duty(Period);
      Duty_1     <= park_duty(Period);
      Duty_2     <= park_duty(Period);
      Duty_Valid <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      Duty_Valid <= 1'b0;
      if (Update_Strobe && state != ST_IDLE)
        Overrun <= 1'b1;
      case (state)
        ST_ACC: begin
          Theta    <= Theta + Phase_Step;
          period_q <= Period;
          amp_q    <= Amplitude;
          k        <= '0;
        end
        ST_SCALE: m_q <= mul_p[31:16];
        ST_MAP: begin
          case (k)
            2'd0:    stage_0 <= map_val;
            2'd1:    stage_1 <= map_val;
            default: stage_2 <= map_val;
          endcase
          k <= k + 2'd1;
        end
        ST_COMMIT: begin
          Duty_0     <= stage_0;
          Duty_1     <= stage_1;
          Duty_2     <= stage_2;
          Duty_Valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
